// File: rtl/register_file_2r1w_pkg.sv
// Shared constants for the 2-read / 1-write register file.
// Combinational definitions only; no latency, no backpressure.
// Imported by the bank and the top level.
package register_file_2r1w_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;

    typedef logic [REG_WIDTH-1:0]      reg_dat_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef reg_dat_t [REG_COUNT-1:0]  reg_array_t;

endpackage

// File: rtl/register_file_2r1w_bank.sv
// Storage bank: 32 x 32-bit resettable flops with a 5:32 write decoder.
// Write takes effect at the clock edge; entries are exposed unregistered.
// No backpressure; a write is always accepted.
module register_bank_32x32
    import register_file_2r1w_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_we,
    input  reg_addr_t  i_waddr,
    input  reg_dat_t   i_wdata,
    output reg_array_t o_entries
);

    logic [REG_COUNT-1:0] w_dec;
    reg_array_t           r_entries;

    assign w_dec = i_we ? (REG_COUNT'(1) << i_waddr) : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_entries <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_dec[i]) begin
                    r_entries[i] <= i_wdata;
                end
            end
        end
    end

    assign o_entries = r_entries;

endmodule

// File: rtl/register_file_2r1w_mux.sv
// Library mux cells: 32-bit 32:1 and 32-bit 2:1 selectors.
// Purely combinational; zero latency.
// No flow control.
module MUX32_32x1
    import register_file_2r1w_pkg::*;
(
    input  reg_array_t i_d,
    input  reg_addr_t  i_sel,
    output reg_dat_t   o_y
);

    assign o_y = i_d[i_sel];

endmodule

module MUX32_2x1
    import register_file_2r1w_pkg::*;
(
    input  reg_dat_t i_d0,
    input  reg_dat_t i_d1,
    input  logic     i_sel,
    output reg_dat_t o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/register_file_2r1w.sv
// 32 x 32 register file, two read ports with write-first forwarding, one write port.
// Read data registered: one-cycle latency, RD_VALID marks the cycle after a READ.
// No backpressure; every READ/WRITE is accepted on the edge it is sampled.
module register_file_2r1w
    import register_file_2r1w_pkg::*;
#(
    parameter int DATA_WIDTH = REG_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int ZERO_REG   = register_file_2r1w_pkg::ZERO_REG
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    reg_array_t w_entries;
    reg_dat_t   w_mux_r1;
    reg_dat_t   w_mux_r2;
    reg_dat_t   w_fwd_r1;
    reg_dat_t   w_fwd_r2;
    logic       w_we;
    logic       w_hit_r1;
    logic       w_hit_r2;

    reg_dat_t   r_data_r1;
    reg_dat_t   r_data_r2;
    logic       r_rd_valid;

    // Writes to the hardwired-zero index never reach the bank.
    assign w_we     = WRITE && (ADDR_W != ZERO_ADDR);
    assign w_hit_r1 = WRITE && (ADDR_W == ADDR_R1);
    assign w_hit_r2 = WRITE && (ADDR_W == ADDR_R2);

    register_bank_32x32 u_bank (
        .CLK       (CLK),
        .RST       (RST),
        .i_we      (w_we),
        .i_waddr   (ADDR_W),
        .i_wdata   (DATA_W),
        .o_entries (w_entries)
    );

    MUX32_32x1 u_rd_mux_r1 (
        .i_d   (w_entries),
        .i_sel (ADDR_R1),
        .o_y   (w_mux_r1)
    );

    MUX32_32x1 u_rd_mux_r2 (
        .i_d   (w_entries),
        .i_sel (ADDR_R2),
        .o_y   (w_mux_r2)
    );

    MUX32_2x1 u_fwd_mux_r1 (
        .i_d0  (w_mux_r1),
        .i_d1  (DATA_W),
        .i_sel (w_hit_r1),
        .o_y   (w_fwd_r1)
    );

    MUX32_2x1 u_fwd_mux_r2 (
        .i_d0  (w_mux_r2),
        .i_d1  (DATA_W),
        .i_sel (w_hit_r2),
        .o_y   (w_fwd_r2)
    );

    // Zero override sits after forwarding so a dropped r0 write never leaks out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_r1  <= '0;
            r_data_r2  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= READ;
            if (READ) begin
                r_data_r1 <= (ADDR_R1 == ZERO_ADDR) ? '0 : w_fwd_r1;
                r_data_r2 <= (ADDR_R2 == ZERO_ADDR) ? '0 : w_fwd_r2;
            end
        end
    end

    assign DATA_R1  = r_data_r1;
    assign DATA_R2  = r_data_r2;
    assign RD_VALID = r_rd_valid;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Randomized + directed bench for register_file_2r1w with a queue-based scoreboard.
module tb_register_file_2r1w;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
    } rd_exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [4:0]  ADDR_R1 = '0;
    logic [4:0]  ADDR_R2 = '0;
    logic [4:0]  ADDR_W = '0;
    logic [31:0] DATA_W = '0;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        RD_VALID;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [32];
    rd_exp_t     sb_q [$];
    logic [31:0] last_d1 = '0;
    logic [31:0] last_d2 = '0;

    register_file_2r1w dut (
        .CLK      (CLK),
        .RST      (RST),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDR_R1  (ADDR_R1),
        .ADDR_R2  (ADDR_R2),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DATA_R1  (DATA_R1),
        .DATA_R2  (DATA_R2),
        .RD_VALID (RD_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; the expected read result comes from the array model.
    task automatic do_cycle(input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                            input logic wr, input logic [4:0] aw, input logic [31:0] wd);
        rd_exp_t e;
        @(negedge CLK);
        #2;
        READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
        WRITE = wr; ADDR_W = aw; DATA_W = wd;
        if (rd) begin
            e.d1 = (a1 == 0) ? 32'h0 : (wr && aw == a1) ? wd : model[a1];
            e.d2 = (a2 == 0) ? 32'h0 : (wr && aw == a2) ? wd : model[a2];
            sb_q.push_back(e);
        end
        if (wr && aw != 0) model[aw] = wd;
    endtask

    task automatic idle();
        do_cycle(1'b0, 5'($urandom), 5'($urandom), 1'b0, 5'($urandom), $urandom);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        sb_q.delete();
        last_d1 = 32'h0;
        last_d2 = 32'h0;
    endtask

    // Monitor: one cycle after each issued READ the DUT must present the queued data;
    // on other cycles RD_VALID must be low and outputs must hold.
    always begin
        rd_exp_t e;
        @(negedge CLK);
        #1;
        if (RST) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rd_valid_hi", {31'b0, RD_VALID}, 32'h1);
                check("data_r1", DATA_R1, e.d1);
                check("data_r2", DATA_R2, e.d2);
                last_d1 = e.d1;
                last_d2 = e.d2;
            end else begin
                check("rd_valid_lo", {31'b0, RD_VALID}, 32'h0);
                check("hold_r1", DATA_R1, last_d1);
                check("hold_r2", DATA_R2, last_d2);
            end
        end
    end

    initial begin
        clear_model();
        #1;
        check("rst_r1", DATA_R1, 32'h0);
        check("rst_r2", DATA_R2, 32'h0);
        check("rst_vld", {31'b0, RD_VALID}, 32'h0);
        @(negedge CLK);
        #2;
        RST = 1'b1;

        for (int i = 1; i < 32; i++) do_cycle(1'b1, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0);

        do_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        do_cycle(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);

        do_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        do_cycle(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        do_cycle(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);

        do_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5);
        do_cycle(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 32'h12345678);
        idle();
        do_cycle(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);

        // Hold: READ then idle with changed addresses.
        do_cycle(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 32'h0);
        do_cycle(1'b0, 5'd7, 5'd1, 1'b1, 5'd5, 32'h0BADF00D);
        idle();

        for (int i = 1; i < 32; i++) do_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) do_cycle(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            do_cycle(1'($urandom), 5'($urandom), 5'($urandom),
                     1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        // Mid-cycle reset with live nonzero contents and a read in flight.
        do_cycle(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 32'hCAFEF00D);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("mid_rst_r1", DATA_R1, 32'h0);
        check("mid_rst_r2", DATA_R2, 32'h0);
        check("mid_rst_vld", {31'b0, RD_VALID}, 32'h0);
        clear_model();
        READ = 1'b0;
        WRITE = 1'b0;
        @(negedge CLK);
        #2;
        RST = 1'b1;
        for (int i = 1; i < 32; i++) do_cycle(1'b1, 5'(i), 5'(i), 1'b0, 5'd0, 32'h0);

        idle();
        idle();
        idle();
        @(negedge CLK);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
